// File: rtl/mandel_pkg.sv
// Shared Q4.28 constants, default widths and FSM encoding for the Mandelbrot engine.
package mandel_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_FRAC   = 28;
    localparam int DEF_ITER_W = 16;

    localparam logic [31:0] ONE  = 32'h1000_0000;
    localparam logic [31:0] TWO  = 32'h2000_0000;
    localparam logic [31:0] FOUR = 32'h4000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/fixed_mul.sv
// Signed fixed-point multiplier, fixed 3-cycle latency; result is the product
// arithmetically shifted right by FRAC and truncated to WIDTH bits.
module fixed_mul #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] p
);
    logic [3:1]                vld_pipe;
    logic signed [WIDTH-1:0]   a_q, b_q;
    logic signed [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]          p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            p_q      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2:1], valid_in};
            a_q      <= a;
            b_q      <= b;
            prod_q   <= (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
            // Taking the slice is an arithmetic shift by FRAC (floor rounding).
            p_q      <= prod_q[FRAC +: WIDTH];
        end
    end

    assign valid_out = vld_pipe[3];
    assign p         = p_q;
endmodule

// File: rtl/mandel_iter.sv
// Per-pixel Mandelbrot iteration engine: loops z = z^2 + c on three parallel
// fixed_mul instances and reports the escape iteration over valid/ready.
module mandel_iter
    import mandel_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FRAC   = DEF_FRAC,
    parameter int ITER_W = DEF_ITER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_cx,
    input  logic [WIDTH-1:0]  in_cy,
    input  logic [ITER_W-1:0] in_max_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped
);
    localparam logic signed [WIDTH:0] FOUR_X = $signed((WIDTH+1)'(FOUR));
    localparam logic signed [WIDTH:0] TWO_X  = $signed((WIDTH+1)'(TWO));
    localparam logic signed [WIDTH:0] NTWO_X = -TWO_X;

    state_t state, state_d;

    logic signed [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [ITER_W-1:0]       max_q, max_d, iter_q, iter_d;
    logic [ITER_W-1:0]       out_iter_q, out_iter_d;
    logic                    esc_q, esc_d;
    logic                    rst_done;

    logic                    mul_valid;
    logic                    v_xx, v_yy, v_xy, mul_done;
    logic signed [WIDTH-1:0] x2, y2, xy;
    logic signed [WIDTH:0]   xy_x, s, nx, ny;
    logic                    guard;

    assign mul_valid = (state == S_ISSUE);

    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_xx (
        .clk(clk), .rst_n(~rst), .valid_in(mul_valid),
        .a(x_q), .b(x_q), .valid_out(v_xx), .p(x2)
    );
    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_yy (
        .clk(clk), .rst_n(~rst), .valid_in(mul_valid),
        .a(y_q), .b(y_q), .valid_out(v_yy), .p(y2)
    );
    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_xy (
        .clk(clk), .rst_n(~rst), .valid_in(mul_valid),
        .a(x_q), .b(y_q), .valid_out(v_xy), .p(xy)
    );

    assign mul_done = v_xx & v_yy & v_xy;

    // One extra bit keeps 2*xy (up to 8.0) and the sums from wrapping.
    assign xy_x  = {xy[WIDTH-1], xy};
    assign s     = x2 + y2;
    assign nx    = x2 - y2 + cx_q;
    assign ny    = (xy_x <<< 1) + cy_q;
    assign guard = (nx > TWO_X) || (nx < NTWO_X) || (ny > TWO_X) || (ny < NTWO_X);

    always_comb begin
        state_d    = state;
        cx_d       = cx_q;
        cy_d       = cy_q;
        max_d      = max_q;
        x_d        = x_q;
        y_d        = y_q;
        iter_d     = iter_q;
        out_iter_d = out_iter_q;
        esc_d      = esc_q;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    cx_d    = in_cx;
                    cy_d    = in_cy;
                    max_d   = in_max_iter;
                    x_d     = '0;
                    y_d     = '0;
                    iter_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    if (s > FOUR_X) begin
                        out_iter_d = iter_q;
                        esc_d      = 1'b1;
                        state_d    = S_DONE;
                    end else if (iter_q == max_q) begin
                        out_iter_d = iter_q;
                        esc_d      = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        iter_d = iter_q + 1'b1;
                        // Leaving [-2,2] would overflow Q4.28 on the next squaring.
                        if (guard) begin
                            out_iter_d = iter_q + 1'b1;
                            esc_d      = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            x_d     = nx[WIDTH-1:0];
                            y_d     = ny[WIDTH-1:0];
                            state_d = S_ISSUE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            max_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            iter_q     <= '0;
            out_iter_q <= '0;
            esc_q      <= 1'b0;
            rst_done   <= 1'b0;
        end else begin
            state      <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            max_q      <= max_d;
            x_q        <= x_d;
            y_q        <= y_d;
            iter_q     <= iter_d;
            out_iter_q <= out_iter_d;
            esc_q      <= esc_d;
            rst_done   <= 1'b1;
        end
    end

    assign in_ready    = (state == S_IDLE) && rst_done;
    assign out_valid   = (state == S_DONE);
    assign out_iter    = out_iter_q;
    assign out_escaped = esc_q;
endmodule

// File: tb/tb_mandel_iter.sv
// Self-checking bench for mandel_iter: directed points, random points against a
// plain-arithmetic orbit model, backpressure and mid-run reset.
module tb_mandel_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_cx, in_cy;
    logic [15:0] in_max_iter;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_iter;
    logic        out_escaped;

    int n_cmp = 0;
    int n_bad = 0;

    mandel_iter dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cx(in_cx), .in_cy(in_cy), .in_max_iter(in_max_iter),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_iter(out_iter), .out_escaped(out_escaped)
    );

    always #5 clk = ~clk;

    // Orbit model: floor-rounded Q4.28 products, escape/limit/guard rules.
    // rounds = index of the deciding round; result latency is 5 + 4*rounds.
    function automatic void model(input logic [31:0] cx, input logic [31:0] cy,
                                  input int mx, output int it, output bit esc,
                                  output int rounds);
        longint x = 0, y = 0, x2, y2, xy, nx, ny, scx, scy;
        int i = 0;
        scx = longint'($signed(cx));
        scy = longint'($signed(cy));
        while (1) begin
            x2 = (x * x) >>> 28;
            y2 = (y * y) >>> 28;
            xy = (x * y) >>> 28;
            if (x2 + y2 > 64'sh4000_0000) begin
                it = i; esc = 1; rounds = i; return;
            end
            if (i == mx) begin
                it = i; esc = 0; rounds = i; return;
            end
            nx = x2 - y2 + scx;
            ny = 2 * xy + scy;
            i++;
            if (nx > 64'sh2000_0000 || nx < -64'sh2000_0000 ||
                ny > 64'sh2000_0000 || ny < -64'sh2000_0000) begin
                it = i; esc = 1; rounds = i - 1; return;
            end
            x = nx;
            y = ny;
        end
    endfunction

    // Waits for in_ready, submits one point, returns when out_valid is seen
    // (or after a bounded number of cycles). lat counts cycles from accept.
    task automatic run_point(input logic [31:0] cx, input logic [31:0] cy,
                             input logic [15:0] mx, output logic [15:0] it,
                             output logic esc, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_cx = cx; in_cy = cy; in_max_iter = mx;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_cx = $urandom; in_cy = $urandom; in_max_iter = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 4 * int'(mx) + 20) begin
            @(posedge clk); #1; lat++;
        end
        it = out_iter;
        esc = out_escaped;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_iter !== 16'd0 || out_escaped !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%b vld=%b iter=%0d esc=%b required 0/0/0/0",
                     in_ready, out_valid, out_iter, out_escaped);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] cxs  [4] = '{32'h0, 32'h1000_0000, 32'h0800_0000, 32'hE000_0000};
        logic [31:0] cys  [4] = '{32'h0, 32'h1000_0000, 32'h0,         32'h0};
        logic [15:0] mxs  [4] = '{16'd100, 16'd50, 16'd50, 16'd50};
        logic [15:0] eit  [4] = '{16'd100, 16'd2, 16'd5, 16'd50};
        logic        eesc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          elat [4] = '{405, 9, 21, 205};
        logic [15:0] it;
        logic        esc;
        int          lat;
        for (int k = 0; k < 4; k++) begin
            run_point(cxs[k], cys[k], mxs[k], it, esc, lat);
            n_cmp++;
            if (it !== eit[k] || esc !== eesc[k]) begin
                n_bad++;
                $display("FAIL directed_%0d: iter=%0d esc=%b required iter=%0d esc=%b",
                         k, it, esc, eit[k], eesc[k]);
            end
            n_cmp++;
            if (lat !== elat[k]) begin
                n_bad++;
                $display("FAIL directed_lat_%0d: latency=%0d required %0d", k, lat, elat[k]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_release_%0d: vld=%b rdy=%b required 0/1",
                         k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] cx, cy;
        logic [15:0] mx, it;
        logic        esc;
        int          lat, eit, erounds;
        bit          eesc;
        for (int k = 0; k < 30; k++) begin
            cx = $urandom_range(32'h4000_0000, 0) - 32'h2000_0000;
            cy = $urandom_range(32'h4000_0000, 0) - 32'h2000_0000;
            if (k < 10) begin
                cx = cx >>> 1;
                cy = cy >>> 2;
            end
            mx = 16'($urandom_range(40, 0));
            model(cx, cy, int'(mx), eit, eesc, erounds);
            run_point(cx, cy, mx, it, esc, lat);
            n_cmp++;
            if (int'(it) != eit || esc !== eesc || lat != 5 + 4 * erounds) begin
                n_bad++;
                $display("FAIL random_%0d: c=(%h,%h) max=%0d got iter=%0d esc=%b lat=%0d required iter=%0d esc=%b lat=%0d",
                         k, cx, cy, mx, it, esc, lat, eit, eesc, 5 + 4 * erounds);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] it;
        logic        esc;
        int          lat;
        out_ready = 1'b0;
        run_point(32'h1000_0000, 32'h1000_0000, 16'd50, it, esc, lat);
        n_cmp++;
        if (out_valid !== 1'b1 || it !== 16'd2 || esc !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_result: vld=%b iter=%0d esc=%b required 1/2/1", out_valid, it, esc);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_iter !== 16'd2 || out_escaped !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: vld=%b iter=%0d esc=%b rdy=%b required 1/2/1/0",
                         c, out_valid, out_iter, out_escaped, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_bubble: in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: vld=%b rdy=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] it;
        logic        esc;
        int          lat;
        int          w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        in_valid = 1'b1; in_cx = 32'h0; in_cy = 32'h0; in_max_iter = 16'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_iter !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_mid_state: vld=%b rdy=%b iter=%0d required 0/0/0",
                     out_valid, in_ready, out_iter);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_ready: in_ready=%b required 1", in_ready);
        end
        run_point(32'h0, 32'h0, 16'd0, it, esc, lat);
        n_cmp++;
        if (it !== 16'd0 || esc !== 1'b0 || lat != 5) begin
            n_bad++;
            $display("FAIL rst_mid_fresh: iter=%0d esc=%b lat=%0d required 0/0/5", it, esc, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cx = '0; in_cy = '0; in_max_iter = '0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
